// File: rtl/afifo_pkg.sv
// Shared types and helpers for the AFIFO write-side scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package afifo_pkg;

    localparam int DATA_WIDTH_DEF = 64;

    // Width of an index into n items; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [DATA_WIDTH_DEF-1:0] beat_t;

endpackage

// File: rtl/afifo_rr_pick.sv
// Rotate-priority winner select: owner if keep and still requesting, else first requester after owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module afifo_rr_pick
    import afifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    owner,
    input  logic             keep,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IW-1:0]    grant_idx,
    output logic             any
);

    logic          found;
    logic [IW-1:0] cand;

    // Stay with the owner while its burst is live, otherwise scan cyclically from owner+1.
    always_comb begin
        found        = 1'b0;
        cand         = '0;
        grant_idx    = owner;
        grant_onehot = '0;
        any          = |req;
        if (keep && req[owner]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(owner) + k) % N_REQ);
            if (!found && req[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
        if (found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin scheduler sharing one AFIFO write port among N_REQ producers, with bounded bursts.
// Latency: ack to fifo_enq is one cycle minimum through a single registered beat.
// Backpressure: fifo_full holds the registered beat and withholds ack; the held beat is replaced on the cycle it drains.
module afifo_wr_arbiter
    import afifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    input  logic                        fifo_full,
    output logic                        fifo_enq,
    output logic [DATA_WIDTH-1:0]       fifo_data,
    output logic [$clog2(N_REQ)-1:0]    owner,
    output logic [CNT_WIDTH-1:0]        total_cnt
);

    localparam int IW = idx_w(N_REQ);
    localparam int BW = idx_w(BURST);

    logic                  ov;
    logic [DATA_WIDTH-1:0] od;
    logic [IW-1:0]         owner_q;
    logic [BW-1:0]         burst_cnt;
    // Set by every grant, cleared once the owner stops requesting: after reset or a
    // dropped request the next grant always comes from a full cyclic search.
    logic                  burst_live;

    logic                  keep;
    logic                  keep_hit;
    logic                  load;
    logic [N_REQ-1:0]      grant_onehot;
    logic [IW-1:0]         grant_idx;
    logic                  any;
    logic [DATA_WIDTH-1:0] sel_data;

    assign keep     = burst_live && (int'(burst_cnt) < (BURST - 1));
    assign keep_hit = keep && req[owner_q];

    afifo_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req          (req),
        .owner        (owner_q),
        .keep         (keep),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    // Output stage drains when the FIFO has room; a new beat may enter on the same cycle.
    // Gating with RST_N keeps ack quiet while reset is held.
    always_comb begin
        fifo_enq  = ov && !fifo_full;
        fifo_data = od;
        load      = RST_N && en && (!ov || fifo_enq) && any;
        ack       = load ? grant_onehot : '0;
        owner     = owner_q;
    end

    // Select the winning requester's beat from the flattened bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register, owner and burst tracking.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ov         <= 1'b0;
            od         <= '0;
            owner_q    <= IW'(N_REQ - 1);
            burst_cnt  <= '0;
            burst_live <= 1'b0;
        end else if (load) begin
            ov         <= 1'b1;
            od         <= sel_data;
            owner_q    <= grant_idx;
            burst_cnt  <= keep_hit ? (burst_cnt + BW'(1)) : '0;
            burst_live <= 1'b1;
        end else begin
            if (fifo_enq) begin
                ov <= 1'b0;
            end
            if (!req[owner_q]) begin
                burst_live <= 1'b0;
            end
        end
    end

    // Free-running count of beats handed to the FIFO.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            total_cnt <= '0;
        end else if (fifo_enq) begin
            total_cnt <= total_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
